// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters (core LSU "C", UART loader "L"),
// the data-memory arbiter and the single-port data memory.
// Ports: C/L request channels (valid/we/addr/wdata -> ready),
//        C/L response channels (rvalid/rdata/err), l_lock, err_sticky,
//        memory side (mem_addr/mem_din/mem_we out, mem_dout in).
interface data_mem_arbiter_if;
    logic        c_valid;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_ready;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic        c_err;

    logic        l_valid;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_ready;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        l_err;

    logic        l_lock;
    logic        err_sticky;

    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;

    // Arbiter side.
    modport slave (
        input  c_valid, c_we, c_addr, c_wdata,
        input  l_valid, l_we, l_addr, l_wdata,
        input  l_lock, mem_dout,
        output c_ready, c_rvalid, c_rdata, c_err,
        output l_ready, l_rvalid, l_rdata, l_err,
        output err_sticky, mem_addr, mem_din, mem_we
    );

    // Requester / memory side.
    modport master (
        output c_valid, c_we, c_addr, c_wdata,
        output l_valid, l_we, l_addr, l_wdata,
        output l_lock, mem_dout,
        input  c_ready, c_rvalid, c_rdata, c_err,
        input  l_ready, l_rvalid, l_rdata, l_err,
        input  err_sticky, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter (with L-exclusive lock) in front of the data memory.
// Ports: clk, rst (sync, active high), bus (data_mem_arbiter_if.slave).
// One issue per cycle; response and write strobe follow one cycle later.
module data_mem_arbiter #(
    parameter int ADDRW = 6
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

    logic        gnt_c, gnt_l, issue;
    logic        sel_we, sel_err;
    logic [31:0] sel_addr, sel_wdata;

    logic        p_valid_q, p_valid_d;
    logic        p_port_q, p_port_d;
    logic        p_we_q, p_we_d;
    logic        p_err_q, p_err_d;
    logic        rr_last_q, rr_last_d;
    logic        sticky_q, sticky_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mdin_q, mdin_d;

    logic resp_ok, good_rd;

    // Grant: lock gives L exclusive access; ties go to the port
    // that was not granted last. Nothing is granted during reset.
    always_comb begin
        gnt_c = 1'b0;
        gnt_l = 1'b0;
        if (!rst) begin
            if (bus.l_lock) begin
                gnt_l = bus.l_valid;
            end else if (bus.c_valid && bus.l_valid) begin
                gnt_c = (rr_last_q == PORT_L);
                gnt_l = (rr_last_q == PORT_C);
            end else begin
                gnt_c = bus.c_valid;
                gnt_l = bus.l_valid;
            end
        end
    end

    assign issue     = gnt_c | gnt_l;
    assign sel_addr  = gnt_l ? bus.l_addr  : bus.c_addr;
    assign sel_wdata = gnt_l ? bus.l_wdata : bus.c_wdata;
    assign sel_we    = gnt_l ? bus.l_we    : bus.c_we;
    assign sel_err   = (|sel_addr[1:0]) | (|sel_addr[31:ADDRW+2]);

    always_comb begin
        p_valid_d = issue;
        p_port_d  = p_port_q;
        p_we_d    = p_we_q;
        p_err_d   = p_err_q;
        rr_last_d = rr_last_q;
        sticky_d  = sticky_q;
        maddr_d   = maddr_q;
        mdin_d    = mdin_q;
        if (issue) begin
            p_port_d  = gnt_l ? PORT_L : PORT_C;
            p_we_d    = sel_we;
            p_err_d   = sel_err;
            rr_last_d = gnt_l ? PORT_L : PORT_C;
            sticky_d  = sticky_q | sel_err;
            // Rejected requests still drive the bus; mem_we stays low.
            maddr_d   = sel_addr;
            mdin_d    = sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q <= 1'b0;
            p_port_q  <= PORT_C;
            p_we_q    <= 1'b0;
            p_err_q   <= 1'b0;
            rr_last_q <= PORT_L;
            sticky_q  <= 1'b0;
            maddr_q   <= '0;
            mdin_q    <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_port_q  <= p_port_d;
            p_we_q    <= p_we_d;
            p_err_q   <= p_err_d;
            rr_last_q <= rr_last_d;
            sticky_q  <= sticky_d;
            maddr_q   <= maddr_d;
            mdin_q    <= mdin_d;
        end
    end

    // Reset in the response cycle cancels both the write and the response.
    assign resp_ok = p_valid_q & ~rst;
    assign good_rd = resp_ok & ~p_we_q & ~p_err_q;

    assign bus.c_ready    = gnt_c;
    assign bus.l_ready    = gnt_l;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_din    = mdin_q;
    assign bus.mem_we     = resp_ok & p_we_q & ~p_err_q;
    assign bus.err_sticky = sticky_q;

    assign bus.c_rvalid = resp_ok & (p_port_q == PORT_C);
    assign bus.l_rvalid = resp_ok & (p_port_q == PORT_L);
    assign bus.c_err    = bus.c_rvalid & p_err_q;
    assign bus.l_err    = bus.l_rvalid & p_err_q;
    assign bus.c_rdata  = (good_rd && p_port_q == PORT_C) ? bus.mem_dout : '0;
    assign bus.l_rdata  = (good_rd && p_port_q == PORT_L) ? bus.mem_dout : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: grant table, directed sequences and
// randomized traffic checked against a transaction-level memory model.
module tb_data_mem_arbiter;
    localparam int ADDRW = 6;
    localparam int DEPTH = 1 << ADDRW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if bus();

    data_mem_arbiter #(.ADDRW(ADDRW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory: address registered by the arbiter, combinational read,
    // write committed at the end of the mem_we cycle.
    logic [31:0] tmem [DEPTH];
    assign bus.mem_dout = tmem[bus.mem_addr[ADDRW+1:2]];
    always @(posedge clk) begin
        if (bus.mem_we) tmem[bus.mem_addr[ADDRW+1:2]] <= bus.mem_din;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    typedef struct {
        bit          v;
        bit          port;
        bit          we;
        bit          err;
        int          idx;
        logic [31:0] wd;
    } pend_t;

    pend_t       pend;
    bit          m_rr;
    bit          m_sticky;
    logic [31:0] m_maddr, m_mdin;
    logic [31:0] ref_mem [DEPTH];

    task automatic ce(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mgrant(output bit gc, output bit gl);
        gc = 0;
        gl = 0;
        if (rst) return;
        if (bus.l_lock) gl = bus.l_valid;
        else if (bus.c_valid && bus.l_valid) begin
            if (m_rr) gc = 1;
            else gl = 1;
        end else begin
            gc = bus.c_valid;
            gl = bus.l_valid;
        end
    endfunction

    task automatic drv(bit cv, bit cw, logic [31:0] ca, logic [31:0] cd,
                       bit lv, bit lw, logic [31:0] la, logic [31:0] ld,
                       bit lk);
        bus.c_valid = cv;  bus.c_we = cw;  bus.c_addr = ca;  bus.c_wdata = cd;
        bus.l_valid = lv;  bus.l_we = lw;  bus.l_addr = la;  bus.l_wdata = ld;
        bus.l_lock  = lk;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare every output with the model, mid-cycle.
    task automatic chk();
        bit gc, gl, ok, rc, rl;
        logic [31:0] rd;
        #2;
        mgrant(gc, gl);
        ok = pend.v && !rst;
        rc = ok && pend.port == 0;
        rl = ok && pend.port == 1;
        rd = (ok && !pend.we && !pend.err) ? ref_mem[pend.idx] : 32'h0;
        ce("c_ready",    bus.c_ready,    gc);
        ce("l_ready",    bus.l_ready,    gl);
        ce("c_rvalid",   bus.c_rvalid,   rc);
        ce("l_rvalid",   bus.l_rvalid,   rl);
        ce("c_err",      bus.c_err,      rc && pend.err);
        ce("l_err",      bus.l_err,      rl && pend.err);
        ce("c_rdata",    bus.c_rdata,    rc ? rd : 32'h0);
        ce("l_rdata",    bus.l_rdata,    rl ? rd : 32'h0);
        ce("mem_we",     bus.mem_we,     ok && pend.we && !pend.err);
        ce("err_sticky", bus.err_sticky, m_sticky);
        ce("mem_addr",   bus.mem_addr,   m_maddr);
        ce("mem_din",    bus.mem_din,    m_mdin);
    endtask

    // Advance one clock and update the model from the sampled inputs.
    task automatic adv();
        bit gc, gl;
        logic [31:0] a;
        @(posedge clk);
        mgrant(gc, gl);
        if (pend.v && !rst && pend.we && !pend.err) ref_mem[pend.idx] = pend.wd;
        if (rst) begin
            pend.v   = 0;
            m_rr     = 1;
            m_sticky = 0;
            m_maddr  = 0;
            m_mdin   = 0;
        end else begin
            pend.v = gc | gl;
            if (gc | gl) begin
                a         = gl ? bus.l_addr : bus.c_addr;
                pend.port = gl;
                pend.we   = gl ? bus.l_we : bus.c_we;
                pend.wd   = gl ? bus.l_wdata : bus.c_wdata;
                pend.err  = (a[1:0] != 0) || (a[31:ADDRW+2] != 0);
                pend.idx  = int'(a[ADDRW+1:2]);
                m_rr      = gl;
                m_maddr   = a;
                m_mdin    = pend.wd;
                if (pend.err) m_sticky = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        chk();
        adv();
    endtask

    typedef struct {
        bit cv;
        bit lv;
        bit lk;
        bit exp_cr;
        bit exp_lr;
    } gvec_t;

    gvec_t gtab [12];

    initial begin
        gtab[0]  = '{1, 1, 0, 1, 0};
        gtab[1]  = '{1, 1, 0, 0, 1};
        gtab[2]  = '{1, 1, 0, 1, 0};
        gtab[3]  = '{1, 1, 0, 0, 1};
        gtab[4]  = '{1, 1, 1, 0, 1};
        gtab[5]  = '{1, 1, 1, 0, 1};
        gtab[6]  = '{1, 1, 1, 0, 1};
        gtab[7]  = '{1, 1, 0, 1, 0};
        gtab[8]  = '{0, 1, 0, 0, 1};
        gtab[9]  = '{1, 0, 1, 0, 0};
        gtab[10] = '{0, 0, 0, 0, 0};
        gtab[11] = '{1, 0, 0, 1, 0};

        for (int i = 0; i < DEPTH; i++) begin
            tmem[i]    = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        pend     = '{0, 0, 0, 0, 0, 32'h0};
        m_rr     = 1;
        m_sticky = 0;
        m_maddr  = 0;
        m_mdin   = 0;
        idle();
        rst = 1;
        @(negedge clk);
        drv(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, 0);
        chk();
        ce("rst_c_ready", bus.c_ready, 0);
        ce("rst_mem_addr", bus.mem_addr, 0);
        adv();
        idle();
        rst = 0;

        // Grant table: round-robin, lock, release.
        for (int i = 0; i < 12; i++) begin
            drv(gtab[i].cv, 0, 32'h20, 0, gtab[i].lv, 0, 32'h24, 0, gtab[i].lk);
            chk();
            ce($sformatf("tab%0d_c_ready", i), bus.c_ready, gtab[i].exp_cr);
            ce($sformatf("tab%0d_l_ready", i), bus.l_ready, gtab[i].exp_lr);
            adv();
        end
        idle();
        cyc();

        // Write then read-after-write on C.
        drv(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        cyc();
        drv(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        chk();
        ce("raw_c_rvalid", bus.c_rvalid, 1);
        ce("raw_c_err", bus.c_err, 0);
        ce("raw_mem_we", bus.mem_we, 1);
        adv();
        idle();
        chk();
        ce("raw_rdata", bus.c_rdata, 32'hDEAD_BEEF);
        adv();

        // Rejected requests: misaligned on L, out of range on C.
        drv(0, 0, 0, 0, 1, 1, 32'h2, 32'h5555_5555, 0);
        cyc();
        drv(1, 1, 32'h100, 32'h6666_6666, 0, 0, 0, 0, 0);
        chk();
        ce("mis_l_err", bus.l_err, 1);
        ce("mis_mem_we", bus.mem_we, 0);
        adv();
        drv(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk();
        ce("oor_c_err", bus.c_err, 1);
        ce("oor_mem_we", bus.mem_we, 0);
        ce("oor_sticky", bus.err_sticky, 1);
        adv();
        idle();
        chk();
        ce("err_prior_rdata", bus.c_rdata, 32'hA500_0000);
        adv();

        // Reset in the response cycle drops the write.
        drv(1, 1, 32'h8, 32'h1234_5678, 0, 0, 0, 0, 0);
        cyc();
        idle();
        rst = 1;
        chk();
        ce("rstw_mem_we", bus.mem_we, 0);
        ce("rstw_c_rvalid", bus.c_rvalid, 0);
        adv();
        rst = 0;
        drv(1, 0, 32'h8, 0, 0, 0, 0, 0, 0);
        cyc();
        idle();
        chk();
        ce("rstw_old_data", bus.c_rdata, 32'hA500_0002);
        adv();

        // Burst: 8 L writes, then 8 back-to-back C reads.
        for (int i = 0; i < 8; i++) begin
            drv(0, 0, 0, 0, 1, 1, 32'(i * 4), 32'hB000_0000 + 32'(i), 0);
            cyc();
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drv(1, 0, 32'(i * 4), 0, 0, 0, 0, 0, 0);
            else idle();
            chk();
            if (i > 0) begin
                ce($sformatf("burst%0d_rvalid", i - 1), bus.c_rvalid, 1);
                ce($sformatf("burst%0d_rdata", i - 1), bus.c_rdata,
                   32'hB000_0000 + 32'(i - 1));
            end
            adv();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ca, la;
            ca = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15) * 4);
            la = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15) * 4);
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ca, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), la, $urandom,
                $urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 39) == 0);
            cyc();
        end
        rst = 0;
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter in front of the single-port data memory. It shares the memory between the CPU core's load/store unit (port C) and the UART program/data loader (port L). Requests are granted round-robin, or exclusively to L while `l_lock` is high. Requests are issued one per cycle and matched to the memory's registered-address protocol: address and data are captured at issue, `mem_we` is asserted in the following cycle, and read data is returned in the following cycle. Out-of-range or misaligned requests are rejected without touching memory.

## Interface
- `ADDRW`, 6, word-address width of the memory (depth 2^ADDRW words); byte addresses at or above 4·2^ADDRW are out of range.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `c_valid` / `l_valid`  in  1  request present on port C / L.
- `c_we` / `l_we`  in  1  1 = write, 0 = read.
- `c_addr` / `l_addr`  in  32  byte address.
- `c_wdata` / `l_wdata`  in  32  write data.
- `c_ready` / `l_ready`  out  1  request accepted (issued) this cycle; combinational from valids, lock and the RR pointer.
- `c_rvalid` / `l_rvalid`  out  1  one-cycle pulse, response for the request issued in the previous cycle (reads and writes).
- `c_rdata` / `l_rdata`  out  32  read data, valid with `rvalid` for reads; 0 for writes and errors.
- `c_err` / `l_err`  out  1  with `rvalid`: request was rejected.
- `l_lock`  in  1  while 1, port C is never granted.
- `err_sticky`  out  1  set by any rejected request; cleared only by reset.
- `mem_addr`  out  32  to memory address; the granted port's address, else held.
- `mem_din`  out  32  to memory write data; the granted port's wdata, else held.
- `mem_we`  out  1  asserted in the cycle after a valid write issue.
- `mem_dout`  in  32  from memory; reflects the address presented in the previous cycle.

## Operation
- Issue cycle t:
  - Grant at most one port.
  - If `l_lock`=1, grant L if `l_valid`.
  - Otherwise, if exactly one port is valid, grant it.
  - If both are valid, grant the port that was not granted last (`rr_last`, reset value = L, so C wins the first tie).
  - `rr_last` updates on every grant, including rejected requests and grants made under lock.
- Validation at issue:
  - Error if `addr[1:0]` ≠ 0.
  - Error if `addr[31:ADDRW+2]` ≠ 0.
  - For an erroneous write, `mem_we` stays 0 in t+1. An erroneous read still drives the address, but its data is discarded.
- Pipeline register (t → t+1): `p_valid`, `p_port`, `p_we`, `p_err`.
- Cycle t+1:
  - `mem_we` = `p_valid & p_we & ~p_err`.
  - `<p_port>_rvalid` = 1 and `<p_port>_err` = `p_err`.
  - `<p_port>_rdata` = `mem_dout` if this is a good read, else 0.
- A new issue may occur in t+1, so back-to-back throughput is 1 request per cycle.
- Responses cannot be stalled; requesters must accept `rvalid` unconditionally.
- Ordering:
  - Per port, responses are returned in issue order.
  - A read issued in the cycle after a write to the same address returns the new data, because the memory commits the write before the read address is sampled. No forwarding logic is needed.
- While no grant occurs, `mem_addr` and `mem_din` hold their last driven values. This is harmless because `mem_we` is 0.

## Timing
- Reset values: `p_valid`=0, `mem_we`=0, all `rvalid`/`err` = 0, all `rdata` = 0, `err_sticky`=0, `rr_last`=L, `mem_addr`=0, `mem_din`=0.
- Reset asserted in cycle t+1 after an issue at t:
  - `mem_we` is forced to 0, so the write is dropped.
  - No `rvalid` is produced.
  - `ready` is 0 during reset.
- Latency: issue to `rvalid` is exactly 1 cycle. Issue to memory commit is at the end of t+1.
- `ready` does not depend on `rvalid` or on any response state.
- `l_lock` rising while a C request is pending in the pipeline: that C response still completes normally in t+1.
- Simultaneous `rvalid` on both ports is impossible, because only one grant is made per cycle.

## Test plan
- Reset, then C writes 0xDEADBEEF to 0x10 (t) and reads 0x10 (t+1):
  - `c_rvalid` at t+1 with `c_err`=0.
  - `mem_we` pulse at t+1.
  - Read response at t+2 with `c_rdata`=0xDEADBEEF.
- C and L both valid for 4 cycles, both reading: grants go C, L, C, L, and each `rvalid` follows its grant by 1 cycle.
- `l_lock`=1 with both valid for 3 cycles:
  - Only L is granted and `c_ready`=0 throughout.
  - After lock drops, the first tie goes to C.
- L writes to 0x2 (misaligned) and C writes to 0x100 with ADDRW=6 (out of range):
  - Each gets `err`=1 with its `rvalid`.
  - `mem_we` stays 0.
  - `err_sticky`=1.
  - A subsequent read of 0x0 returns the prior contents.
- C write issued at t, `rst` asserted at t+1:
  - `mem_we`=0 and no `c_rvalid`.
  - After reset, a read of that address returns the old value.
- Burst of 8 back-to-back L writes to 0x0–0x1C, then 8 C reads: C returns the same data in order, with 1 response per cycle.
